sram_arbiter: RTL and testbench

//  Two-port arbiter sharing the single SRAM controller between requesters.

---
 rtl/sram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between the MEM stage (port 0) and a
// secondary master (port 1), with a watchdog that aborts stuck transactions.
// Ports: clk, rst (sync, active-high); pN_rd_en/pN_wr_en/pN_addr/pN_wdata requests,
//   pN_rdata/pN_done/pN_stall responses; mem_* level interface to the controller;
//   err is a sticky watchdog-abort flag.
// Build option: define ROUND_ROBIN_EN for alternating grants on contention,
//   otherwise port 0 has fixed priority.
module sram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_rd_en,
    input  logic              p0_wr_en,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_done,
    output logic              p0_stall,
    input  logic              p1_rd_en,
    input  logic              p1_wr_en,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_done,
    output logic              p1_stall,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Abort fires at the end of the TIMEOUT-th BUSY cycle.
    localparam logic [3:0] WD_LAST = 4'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wd_q, wd_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              p0_done_q, p0_done_d;
    logic              p1_done_q, p1_done_d;
    logic              err_q, err_d;
`ifdef ROUND_ROBIN_EN
    logic              last_q, last_d;
`endif

    logic req0, req1, gnt1, finish;

    assign req0 = p0_rd_en | p0_wr_en;
    assign req1 = p1_rd_en | p1_wr_en;

`ifdef ROUND_ROBIN_EN
    // On a tie the port that was not granted last time wins.
    assign gnt1 = req1 & (~req0 | ~last_q);
`else
    assign gnt1 = req1 & ~req0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rd_en_d    = rd_en_q;
        wr_en_d    = wr_en_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wd_d       = wd_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        p0_done_d  = 1'b0;
        p1_done_d  = 1'b0;
        err_d      = err_q;
        finish     = 1'b0;
`ifdef ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    owner_d = gnt1;
                    // Read wins when a port raises both enables.
                    rd_en_d = gnt1 ? p1_rd_en : p0_rd_en;
                    wr_en_d = gnt1 ? ~p1_rd_en : ~p0_rd_en;
                    addr_d  = gnt1 ? p1_addr : p0_addr;
                    wdata_d = gnt1 ? p1_wdata : p0_wdata;
                    wd_d    = 4'd0;
                    state_d = BUSY;
`ifdef ROUND_ROBIN_EN
                    last_d  = gnt1;
`endif
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    finish = 1'b1;
                    if (rd_en_q) begin
                        if (owner_q) begin
                            p1_rdata_d = mem_read_data;
                        end else begin
                            p0_rdata_d = mem_read_data;
                        end
                    end
                end else if (wd_q == WD_LAST) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                    if (owner_q) begin
                        p1_rdata_d = '0;
                    end else begin
                        p0_rdata_d = '0;
                    end
                end else begin
                    wd_d = wd_q + 4'd1;
                end
                if (finish) begin
                    rd_en_d   = 1'b0;
                    wr_en_d   = 1'b0;
                    p0_done_d = ~owner_q;
                    p1_done_d = owner_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                // No grant here: a requester dropping at done is not re-served.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wd_q       <= 4'd0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            p0_done_q  <= 1'b0;
            p1_done_q  <= 1'b0;
            err_q      <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wd_q       <= wd_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            p0_done_q  <= p0_done_d;
            p1_done_q  <= p1_done_d;
            err_q      <= err_d;
`ifdef ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign mem_read_en    = rd_en_q;
    assign mem_write_en   = wr_en_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign p0_rdata       = p0_rdata_q;
    assign p1_rdata       = p1_rdata_q;
    assign p0_done        = p0_done_q;
    assign p1_done        = p1_done_q;
    assign err            = err_q;
    assign p0_stall       = req0 & ~p0_done_q;
    assign p1_stall       = req1 & ~p1_done_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized transactions against a transaction-level
// model of the arbiter plus a simple SRAM controller model with programmable latency.
module tb_sram_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_rd_en = 1'b0, p0_wr_en = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic [31:0] p0_rdata;
    logic        p0_done, p0_stall;
    logic        p1_rd_en = 1'b0, p1_wr_en = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic [31:0] p1_rdata;
    logic        p1_done, p1_stall;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_ready;
    logic        err;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .p0_rd_en(p0_rd_en), .p0_wr_en(p0_wr_en), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_done(p0_done),
        .p0_stall(p0_stall),
        .p1_rd_en(p1_rd_en), .p1_wr_en(p1_wr_en), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_done(p1_done),
        .p1_stall(p1_stall),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    // SRAM controller model: ready after 'lat' enabled cycles, storage cleared on rst.
    int          lat = 6;
    int          busy_cnt;
    logic [31:0] cmem [0:1023];

    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
            for (int i = 0; i < 1024; i++) cmem[i] <= '0;
        end else if (mem_read_en | mem_write_en) begin
            if (mem_ready) begin
                busy_cnt <= 0;
                if (mem_write_en) cmem[mem_address[11:2]] <= mem_write_data;
            end else begin
                busy_cnt <= busy_cnt + 1;
            end
        end else begin
            busy_cnt <= 0;
        end
    end

    assign mem_ready     = (mem_read_en | mem_write_en) && (busy_cnt == lat);
    assign mem_read_data = cmem[mem_address[11:2]];

    // Reference model state.
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_rdata [2];
    bit          exp_err;
    bit          last_g;
    int          npass = 0;
    int          ntot = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_err = 1'b0;
        last_g = 1'b1;
    endtask

    task automatic drive(input int port, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            p0_rd_en = rd; p0_wr_en = wr; p0_addr = a; p0_wdata = d;
        end else begin
            p1_rd_en = rd; p1_wr_en = wr; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic drop(input int port);
        if (port == 0) begin
            p0_rd_en = 1'b0; p0_wr_en = 1'b0;
        end else begin
            p1_rd_en = 1'b0; p1_wr_en = 1'b0;
        end
    endtask

    // One uncontended transaction, issued from IDLE.
    task automatic txn(input int port, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d, input int l);
        int n, en_cyc, en_bad, busy, oth;
        bit got, other_done, abort;
        n = 0; en_cyc = 0; en_bad = 0; got = 0; other_done = 0;
        oth = 1 - port;
        @(posedge clk); #1;
        lat = l;
        drive(port, rd, wr, a, d);
        #1;
        check("stall_req", (port == 0) ? p0_stall : p1_stall, 1);
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (mem_read_en | mem_write_en) begin
                en_cyc++;
                if (mem_read_en !== rd || mem_write_en !== !rd ||
                    mem_address !== a || (!rd && mem_write_data !== d)) en_bad++;
            end
            if ((port == 0) ? p1_done : p0_done) other_done = 1;
            got = (port == 0) ? p0_done : p1_done;
        end
        check("done_seen", got, 1);
        check("stall_at_done", (port == 0) ? p0_stall : p1_stall, 0);
        drop(port);
        abort = (l + 1 > TIMEOUT);
        busy = abort ? TIMEOUT : l + 1;
        if (abort) begin
            exp_rdata[port] = '0;
            exp_err = 1'b1;
        end else if (rd) begin
            exp_rdata[port] = ref_mem[a[11:2]];
        end else begin
            ref_mem[a[11:2]] = d;
        end
        last_g = port[0];
        check("latency", n, busy + 1);
        check("en_cycles", en_cyc, busy);
        check("en_signals", en_bad, 0);
        check("other_done", other_done, 0);
        check("rdata_owner", (port == 0) ? p0_rdata : p1_rdata, exp_rdata[port]);
        check("rdata_other", (oth == 0) ? p0_rdata : p1_rdata, exp_rdata[oth]);
        check("err", err, exp_err);
    endtask

    // Both ports read continuously for three rounds.
    task automatic contend();
        int n, won, ew;
        bit got;
        logic [31:0] a [2];
        a[0] = 32'h100;
        a[1] = 32'h200;
        @(posedge clk); #1;
        lat = $urandom_range(0, 5);
        drive(0, 1, 0, a[0], '0);
        drive(1, 1, 0, a[1], '0);
        for (int r = 0; r < 3; r++) begin
`ifdef ROUND_ROBIN_EN
            ew = last_g ? 0 : 1;
`else
            ew = 0;
`endif
            n = 0; got = 0;
            while (!got && n < 40) begin
                @(posedge clk); #1;
                n++;
                got = p0_done | p1_done;
            end
            won = p1_done ? 1 : 0;
            check("c_done", got, 1);
            check("c_single", p0_done & p1_done, 0);
            check("c_winner", won, ew);
            check("c_loser_stall", (won == 0) ? p1_stall : p0_stall, 1);
            exp_rdata[won] = ref_mem[a[won][11:2]];
            last_g = won[0];
            check("c_rdata0", p0_rdata, exp_rdata[0]);
            check("c_rdata1", p1_rdata, exp_rdata[1]);
            lat = $urandom_range(0, 5);
            if (r == 2) begin
                drop(0);
                drop(1);
            end
        end
    endtask

    initial begin
        int port;
        bit rd, wr;
        logic [31:0] a, d;

        ref_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_en", mem_read_en, 0);
        check("rst_wr_en", mem_write_en, 0);
        check("rst_addr", mem_address, 0);
        check("rst_p0_done", p0_done, 0);
        check("rst_p1_rdata", p1_rdata, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        txn(1, 0, 1, 32'h404, 32'h12345678, 6);
        txn(1, 0, 1, 32'h400, 32'hDEADBEEF, 4);
        txn(0, 1, 0, 32'h400, '0, 6);
        check("read_deadbeef", p0_rdata, 32'hDEADBEEF);
        txn(0, 1, 1, 32'h404, 32'hFFFF0000, 3);
        check("rdwr_as_read", p0_rdata, 32'h12345678);

        txn(1, 0, 1, 32'h100, 32'hA0A0A0A0, 2);
        txn(1, 0, 1, 32'h200, 32'hB1B1B1B1, 2);
        contend();

        txn(1, 1, 0, 32'h100, '0, 14);
        txn(0, 1, 0, 32'h200, '0, 0);

        for (int k = 0; k < 16; k++) begin
            port = $urandom_range(0, 1);
            rd = $urandom_range(0, 1);
            wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            a = 32'h40 + 32'($urandom_range(0, 15)) * 4;
            d = $urandom;
            txn(port, rd, wr, a, d, $urandom_range(0, 8));
        end

        txn(0, 1, 0, 32'h404, '0, 1000);
        check("stuck_err", err, 1);
        check("stuck_rdata", p0_rdata, 0);
        txn(1, 0, 1, 32'h44, 32'h5A5A5A5A, 15);
        txn(1, 1, 0, 32'h404, '0, 5);

        @(posedge clk); #1;
        lat = 6;
        drive(0, 1, 0, 32'h400, '0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", mem_read_en, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        drop(0);
        check("mrst_rd_en", mem_read_en, 0);
        check("mrst_wr_en", mem_write_en, 0);
        check("mrst_addr", mem_address, 0);
        check("mrst_wdata", mem_write_data, 0);
        check("mrst_p0_rdata", p0_rdata, 0);
        check("mrst_p1_rdata", p1_rdata, 0);
        check("mrst_done", {p0_done, p1_done}, 0);
        check("mrst_err", err, 0);
        rst = 1'b0;
        ref_reset();

        txn(0, 0, 1, 32'h80, 32'hCAFEF00D, 2);
        txn(1, 1, 0, 32'h80, '0, 6);
        txn(0, 1, 0, 32'h84, '0, 1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
